// File: rtl/trans_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trans_seq_pkg
// Description : Shared state encoding and phase decode for the transaction
//               framing sequence driver.
// Revision    : 1.0 - initial release
// ============================================================================
package trans_seq_pkg;

  // Number of framing pulses: trans, start_trans, a, b, c, end_trans.
  localparam int PHASES = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TRANS = 3'd1,
    START = 3'd2,
    PA    = 3'd3,
    PB    = 3'd4,
    PC    = 3'd5,
    END   = 3'd6,
    GAP   = 3'd7
  } trans_seq_state_t;

  // One-hot phase vector for a state; bit 0 is trans, bit 5 is end_trans.
  function automatic logic [PHASES-1:0] phase_decode(input trans_seq_state_t s);
    logic [PHASES-1:0] p;
    p = '0;
    case (s)
      TRANS:   p[0] = 1'b1;
      START:   p[1] = 1'b1;
      PA:      p[2] = 1'b1;
      PB:      p[3] = 1'b1;
      PC:      p[4] = 1'b1;
      END:     p[5] = 1'b1;
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trans_seq_gap_timer.sv
`default_nettype none
// ============================================================================
// Module      : trans_seq_gap_timer
// Description : Down-counter timing the idle gap after a frame. Loaded on
//               entry to the gap; expired marks the last gap cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module trans_seq_gap_timer #(
  parameter int GAP_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count_en,
  output logic expired
);

  localparam int TW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  // Loading GAP_CYCLES-1 makes the gap last exactly GAP_CYCLES cycles,
  // counting the load cycle itself as the first gap cycle.
  localparam logic [TW-1:0] LOAD_VAL = (GAP_CYCLES > 0) ? TW'(GAP_CYCLES - 1) : '0;

  logic [TW-1:0] count;

  // Load on gap entry, then count down to zero while in the gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count_en && (count != '0)) begin
      count <= count - TW'(1);
    end
  end

  assign expired = (count == '0);

endmodule
`default_nettype wire

// File: rtl/trans_seq_driver.sv
`default_nettype none
// ============================================================================
// Module      : trans_seq_driver
// Description : Initiator-side driver emitting trans, start_trans, a, b, c,
//               end_trans on consecutive cycles per accepted request, with
//               abort, post-frame gap and completed-frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module trans_seq_driver
  import trans_seq_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 8
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             req,
  input  logic             abort,
  output logic             ack,
  output logic             trans,
  output logic             start_trans,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             end_trans,
  output logic             busy,
  output logic             aborted,
  output logic [CNT_W-1:0] done_cnt
);

  // With no gap configured, a finished or aborted frame returns straight to IDLE.
  localparam trans_seq_state_t AFTER_FRAME = (GAP_CYCLES > 0) ? GAP : IDLE;

  trans_seq_state_t  state;
  trans_seq_state_t  next_state;
  logic              abort_take;
  logic              gap_load;
  logic              gap_expired;
  logic [PHASES-1:0] phase;

  trans_seq_gap_timer #(
    .GAP_CYCLES (GAP_CYCLES)
  ) u_gap_timer (
    .clk      (sysclk),
    .rst      (rst),
    .load     (gap_load),
    .count_en (state == GAP),
    .expired  (gap_expired)
  );

  assign gap_load = (next_state == GAP) && (state != GAP);

  // State register.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; abort is honoured only while a frame is mid-flight before END.
  always_comb begin
    next_state = state;
    abort_take = 1'b0;
    case (state)
      IDLE:  if (req) next_state = TRANS;
      TRANS: begin abort_take = abort; next_state = abort ? AFTER_FRAME : START; end
      START: begin abort_take = abort; next_state = abort ? AFTER_FRAME : PA;    end
      PA:    begin abort_take = abort; next_state = abort ? AFTER_FRAME : PB;    end
      PB:    begin abort_take = abort; next_state = abort ? AFTER_FRAME : PC;    end
      PC:    begin abort_take = abort; next_state = abort ? AFTER_FRAME : END;   end
      END:   next_state = AFTER_FRAME;
      GAP:   if (gap_expired) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output flops decoded from next-state so every output is registered.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      phase    <= '0;
      ack      <= 1'b0;
      busy     <= 1'b0;
      aborted  <= 1'b0;
      done_cnt <= '0;
    end else begin
      phase   <= phase_decode(next_state);
      ack     <= (state == IDLE) && (next_state == TRANS);
      busy    <= (next_state != IDLE);
      aborted <= abort_take;
      if (next_state == END) begin
        done_cnt <= done_cnt + CNT_W'(1);
      end
    end
  end

  assign trans       = phase[0];
  assign start_trans = phase[1];
  assign a           = phase[2];
  assign b           = phase[3];
  assign c           = phase[4];
  assign end_trans   = phase[5];

endmodule
`default_nettype wire

// File: tb/tb_trans_seq_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_trans_seq_driver
// Description : Directed self-checking bench for trans_seq_driver. Instance 1
//               uses GAP_CYCLES=2/CNT_W=8, instance 2 uses GAP_CYCLES=0/CNT_W=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trans_seq_driver;

  logic       sysclk = 1'b0;
  logic       rst, req, abort;
  logic       ack, trans, start_trans, a, b, c, end_trans, busy, aborted;
  logic [7:0] done_cnt;

  logic       rst2, req2, abort2;
  logic       ack2, trans2, start_trans2, a2, b2, c2, end_trans2, busy2, aborted2;
  logic [1:0] done_cnt2;

  int         compared   = 0;
  int         mismatched = 0;
  logic [7:0] exp_cnt    = 8'd0;

  // Expected {ack,trans,start_trans,a,b,c,end_trans,busy,aborted} over one
  // GAP_CYCLES=2 frame: six phases, two gap cycles, one idle cycle.
  logic [8:0] frame_exp [9] = '{9'b110000010, 9'b001000010, 9'b000100010,
                                9'b000010010, 9'b000001010, 9'b000000110,
                                9'b000000010, 9'b000000010, 9'b000000000};

  // Same for GAP_CYCLES=0: six phases then one idle cycle.
  logic [8:0] frame0_exp [7] = '{9'b110000010, 9'b001000010, 9'b000100010,
                                 9'b000010010, 9'b000001010, 9'b000000110,
                                 9'b000000000};

  always #5 sysclk = ~sysclk;

  trans_seq_driver #(.GAP_CYCLES(2), .CNT_W(8)) dut (
    .sysclk(sysclk), .rst(rst), .req(req), .abort(abort),
    .ack(ack), .trans(trans), .start_trans(start_trans), .a(a), .b(b), .c(c),
    .end_trans(end_trans), .busy(busy), .aborted(aborted), .done_cnt(done_cnt)
  );

  trans_seq_driver #(.GAP_CYCLES(0), .CNT_W(2)) dut2 (
    .sysclk(sysclk), .rst(rst2), .req(req2), .abort(abort2),
    .ack(ack2), .trans(trans2), .start_trans(start_trans2), .a(a2), .b(b2), .c(c2),
    .end_trans(end_trans2), .busy(busy2), .aborted(aborted2), .done_cnt(done_cnt2)
  );

  a_frame1: assert property (@(posedge sysclk) disable iff (rst || abort)
    trans |=> start_trans ##1 a ##1 b ##1 c ##1 end_trans);
  a_frame2: assert property (@(posedge sysclk) disable iff (rst2 || abort2)
    trans2 |=> start_trans2 ##1 a2 ##1 b2 ##1 c2 ##1 end_trans2);
  a_onehot1: assert property (@(posedge sysclk)
    $onehot0({trans, start_trans, a, b, c, end_trans}));
  a_onehot2: assert property (@(posedge sysclk)
    $onehot0({trans2, start_trans2, a2, b2, c2, end_trans2}));

  function automatic logic [8:0] outs1();
    return {ack, trans, start_trans, a, b, c, end_trans, busy, aborted};
  endfunction

  function automatic logic [8:0] outs2();
    return {ack2, trans2, start_trans2, a2, b2, c2, end_trans2, busy2, aborted2};
  endfunction

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; abort = 1'b0;
    rst2 = 1'b1; req2 = 1'b0; abort2 = 1'b0;
    repeat (3) step();
    compared++;
    if (outs1() !== 9'b0 || done_cnt !== 8'd0) begin
      mismatched++;
      $display("FAIL reset1: outs=%b cnt=%0d, expected outs=0 cnt=0", outs1(), done_cnt);
    end
    compared++;
    if (outs2() !== 9'b0 || done_cnt2 !== 2'd0) begin
      mismatched++;
      $display("FAIL reset2: outs=%b cnt=%0d, expected outs=0 cnt=0", outs2(), done_cnt2);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      if (i == 0) req = 1'b0;
      compared++;
      if (outs1() !== frame_exp[i]) begin
        mismatched++;
        $display("FAIL single[%0d]: outs=%b expected %b", i, outs1(), frame_exp[i]);
      end
      if (i == 5) begin
        exp_cnt = 8'd1;
        compared++;
        if (done_cnt !== exp_cnt) begin
          mismatched++;
          $display("FAIL single_cnt: got %0d expected %0d", done_cnt, exp_cnt);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    req = 1'b1;
    for (int i = 0; i < 18; i++) begin
      step();
      if (i == 17) req = 1'b0;
      compared++;
      if (outs1() !== frame_exp[i % 9]) begin
        mismatched++;
        $display("FAIL b2b[%0d]: outs=%b expected %b", i, outs1(), frame_exp[i % 9]);
      end
      if ((i % 9) == 5) begin
        exp_cnt = exp_cnt + 8'd1;
        compared++;
        if (done_cnt !== exp_cnt) begin
          mismatched++;
          $display("FAIL b2b_cnt[%0d]: got %0d expected %0d", i, done_cnt, exp_cnt);
        end
      end
    end
  endtask

  task automatic test_abort();
    logic [8:0] exp [7] = '{9'b110000010, 9'b001000010, 9'b000100010,
                            9'b000000011, 9'b000000010, 9'b000000000,
                            9'b000000000};
    req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      if (i == 0) req = 1'b0;
      compared++;
      if (outs1() !== exp[i]) begin
        mismatched++;
        $display("FAIL abort[%0d]: outs=%b expected %b", i, outs1(), exp[i]);
      end
      if (i == 2) abort = 1'b1;
      if (i == 3) abort = 1'b0;
    end
    compared++;
    if (done_cnt !== exp_cnt) begin
      mismatched++;
      $display("FAIL abort_cnt: got %0d expected %0d", done_cnt, exp_cnt);
    end
  endtask

  task automatic test_abort_ignored();
    logic [8:0] e;
    req = 1'b1;
    abort = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) begin req = 1'b0; abort = 1'b0; end
      e = (i < 9) ? frame_exp[i] : 9'b0;
      compared++;
      if (outs1() !== e) begin
        mismatched++;
        $display("FAIL abort_ign[%0d]: outs=%b expected %b", i, outs1(), e);
      end
      if (i == 5) begin
        abort = 1'b1;
        exp_cnt = exp_cnt + 8'd1;
        compared++;
        if (done_cnt !== exp_cnt) begin
          mismatched++;
          $display("FAIL abort_ign_cnt: got %0d expected %0d", done_cnt, exp_cnt);
        end
      end
    end
    abort = 1'b0;
  endtask

  task automatic test_reset_midframe();
    req = 1'b1;
    step();
    req = 1'b0;
    step();
    compared++;
    if (outs1() !== 9'b001000010) begin
      mismatched++;
      $display("FAIL mid_pre: outs=%b expected %b", outs1(), 9'b001000010);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 8'd0;
    compared++;
    if (outs1() !== 9'b0 || done_cnt !== 8'd0) begin
      mismatched++;
      $display("FAIL mid_rst: outs=%b cnt=%0d, expected outs=0 cnt=0", outs1(), done_cnt);
    end
    req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      if (i == 0) req = 1'b0;
      compared++;
      if (outs1() !== frame_exp[i]) begin
        mismatched++;
        $display("FAIL mid_new[%0d]: outs=%b expected %b", i, outs1(), frame_exp[i]);
      end
    end
    compared++;
    if (done_cnt !== 8'd1) begin
      mismatched++;
      $display("FAIL mid_cnt: got %0d expected 1", done_cnt);
    end
  endtask

  task automatic test_cnt_wrap();
    logic [1:0] cnt_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst2 = 1'b0;
    step();
    req2 = 1'b1;
    for (int i = 0; i < 35; i++) begin
      step();
      if (i == 34) req2 = 1'b0;
      compared++;
      if (outs2() !== frame0_exp[i % 7]) begin
        mismatched++;
        $display("FAIL wrap[%0d]: outs=%b expected %b", i, outs2(), frame0_exp[i % 7]);
      end
      if ((i % 7) == 5) begin
        compared++;
        if (done_cnt2 !== cnt_exp[i / 7]) begin
          mismatched++;
          $display("FAIL wrap_cnt[%0d]: got %0d expected %0d", i / 7, done_cnt2, cnt_exp[i / 7]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_abort_ignored();
    test_reset_midframe();
    test_cnt_wrap();
    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
